// File: rtl/immu_refill_pkg.sv
// Shared definitions for the instruction-side line refill engine and the
// fetch-side cache that consumes its lines.
package immu_refill_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned LINE_BYTES  = 32;
    localparam int unsigned LINE_OFF_W  = 5;
    localparam int unsigned BEAT_W      = 3;

    // Width of a line address, i.e. the byte address with the line offset dropped.
    localparam int unsigned LINE_ADDR_W = ADDR_W - LINE_OFF_W;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;
    typedef logic [BEAT_W-1:0]      beat_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    // Line-address slice of a byte address.
    function automatic line_addr_t line_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:LINE_OFF_W];
    endfunction

    // Byte address of word 'beat' within 'line'.
    function automatic logic [ADDR_W-1:0] word_addr(input line_addr_t line, input beat_t beat);
        return {line, beat, 2'b00};
    endfunction

endpackage

// File: rtl/immu_refill.sv
// Instruction line refill engine: fetches a 32-byte line as eight word reads,
// keeps the last line in a one-entry buffer, and returns zero lines for
// addresses beyond instruction memory.
module immu_refill
    import immu_refill_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_8000
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         immu_read,
    input  logic [31:0]                  immu_addr,
    input  logic                         inv,
    output logic                         immu_done,
    output logic [LINE_WORDS*WORD_W-1:0] immu_read_data,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_ack,
    input  logic [31:0]                  mem_rdata
);

    localparam int unsigned LINE_W   = LINE_WORDS * WORD_W;
    localparam beat_t       LastBeat = beat_t'(LINE_WORDS - 1);

    state_e                state_q, state_d;
    line_addr_t            line_q, line_d;
    line_addr_t            tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic                  inv_pend_q, inv_pend_d;
    beat_t                 beat_q, beat_d;
    logic [LINE_W-1:0]     data_q, data_d;
    logic                  done_q, done_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           mem_addr_q, mem_addr_d;

    line_addr_t            req_line;
    logic                  req_above;
    logic                  req_hit;

    assign req_line  = line_of(immu_addr);
    assign req_above = ({req_line, {LINE_OFF_W{1'b0}}} >= IMEM_LIMIT);
    // An invalidate arriving in the same cycle as the compare forces a miss.
    assign req_hit   = valid_q && !inv && (tag_q == req_line);

    // Next-state, buffer and registered-output logic for the refill FSM.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        inv_pend_d = inv_pend_q;
        beat_d     = beat_q;
        data_d     = data_q;
        done_d     = 1'b0;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        if (inv) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (immu_read) begin
                    line_d = req_line;
                    if (req_above) begin
                        // The zero line overwrites the buffered data, so the
                        // buffer can no longer claim a hit on its tag.
                        data_d  = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (req_hit) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        beat_d     = '0;
                        valid_d    = 1'b0;
                        inv_pend_d = 1'b0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = word_addr(req_line, '0);
                        state_d    = StFill;
                    end
                end
            end

            StFill: begin
                if (inv) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    data_d[int'(beat_q)*WORD_W +: WORD_W] = mem_rdata;
                    if (beat_q == LastBeat) begin
                        // An invalidate seen at any point during the fill keeps
                        // the freshly filled line out of the buffer.
                        valid_d   = !(inv || inv_pend_q);
                        tag_d     = line_q;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = StDone;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        mem_addr_d = word_addr(line_q, beat_q + 1'b1);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything, including any fill in flight.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            line_q     <= '0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
            inv_pend_q <= 1'b0;
            beat_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            tag_q      <= tag_d;
            valid_q    <= valid_d;
            inv_pend_q <= inv_pend_d;
            beat_q     <= beat_d;
            data_q     <= data_d;
            done_q     <= done_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign immu_done      = done_q;
    assign immu_read_data = data_q;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;

endmodule

// File: tb/tb_immu_refill.sv
// Self-checking bench for immu_refill: table of line requests with a
// scoreboard of expected lines, plus a hand-written reset-mid-fill sequence.
module tb_immu_refill;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         immu_read;
    logic [31:0]  immu_addr;
    logic         inv;
    logic         immu_done;
    logic [255:0] immu_read_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int wcnt     = 0;
    bit wait_mode = 1'b0;
    logic [255:0] sb_q[$];

    immu_refill #(
        .LINE_WORDS(8),
        .IMEM_LIMIT(32'h0000_8000)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .immu_read      (immu_read),
        .immu_addr      (immu_addr),
        .inv            (inv),
        .immu_done      (immu_done),
        .immu_read_data (immu_read_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    // Backing memory returns each word's own byte address as its data.
    assign mem_rdata = mem_addr;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        l    = '0;
        base = {a[31:5], 5'b0};
        if (base < 32'h0000_8000) begin
            for (int i = 0; i < 8; i++) begin
                l[i*32 +: 32] = base + 32'(4 * i);
            end
        end
        return l;
    endfunction

    // Drive mem_ack for the coming edge: every cycle, or every third request cycle.
    task automatic mem_drive();
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (!wait_mode) begin
            mem_ack = 1'b1;
        end else begin
            mem_ack = (wcnt == 2);
            wcnt    = (wcnt == 2) ? 0 : wcnt + 1;
        end
    endtask

    // inv_mode: 0 none, 1 pulse before request, 2 with request, 3 during fill.
    task automatic run_req(input logic [31:0] addr, input int inv_mode, input bit wmode,
                           input int exp_reqs, input int exp_lat, input string tag);
        int           cyc;
        int           reqs;
        int           beat;
        bit           got;
        logic [31:0]  base;
        logic [255:0] exp_line;
        cyc  = 0;
        reqs = 0;
        beat = 0;
        got  = 1'b0;
        base = {addr[31:5], 5'b0};
        wait_mode = wmode;
        if (inv_mode == 1) begin
            inv = 1'b1;
            @(negedge sys_clk);
            inv = 1'b0;
        end
        immu_read = 1'b1;
        immu_addr = addr;
        inv       = (inv_mode == 2);
        sb_q.push_back(model_line(addr));
        mem_drive();
        while (!got && cyc < 300) begin
            @(negedge sys_clk);
            cyc++;
            if (inv_mode == 2) inv = 1'b0;
            // Address changes after sampling must be ignored.
            immu_addr = 32'hDEAD_BEE0;
            if (mem_ack) beat++;
            if (mem_req) begin
                reqs++;
                check({tag, " mem_addr"}, 256'(mem_addr), 256'(base + 32'(4 * beat)));
            end
            if (inv_mode == 3) inv = (mem_req && reqs == 3);
            if (immu_done) begin
                got       = 1'b1;
                immu_read = 1'b0;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s scoreboard: done with no expected line", tag);
                end else begin
                    exp_line = sb_q.pop_front();
                    check({tag, " line"}, immu_read_data, exp_line);
                end
            end
            mem_drive();
        end
        inv = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no immu_done after %0d cycles, expected %0d", tag, cyc,
                     exp_lat);
            immu_read = 1'b0;
            sb_q.delete();
        end else begin
            check({tag, " latency"}, 256'(cyc), 256'(exp_lat));
            check({tag, " mem_req cycles"}, 256'(reqs), 256'(exp_reqs));
        end
        @(negedge sys_clk);
        check({tag, " done single pulse"}, 256'(immu_done), 256'(0));
        mem_drive();
    endtask

    typedef struct {
        logic [31:0] addr;
        int          inv_mode;
        bit          wmode;
        int          exp_reqs;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int acks;
        int cyc;

        // addr, inv_mode, wait, mem_req cycles, latency
        vecs[0]  = '{32'h0000_1000, 0, 1'b0, 8,  9};   // cold miss
        vecs[1]  = '{32'h0000_1010, 0, 1'b0, 0,  1};   // hit, offset ignored
        vecs[2]  = '{32'h0000_101C, 0, 1'b0, 0,  1};   // hit
        vecs[3]  = '{32'h0000_1000, 1, 1'b0, 8,  9};   // inv pulse then refill
        vecs[4]  = '{32'h0000_1000, 2, 1'b0, 8,  9};   // inv with compare misses
        vecs[5]  = '{32'h0000_1004, 0, 1'b0, 0,  1};   // hit
        vecs[6]  = '{32'h0000_2000, 0, 1'b1, 24, 25};  // ack every third cycle
        vecs[7]  = '{32'h0000_2010, 0, 1'b0, 0,  1};   // hit after stalled fill
        vecs[8]  = '{32'h0000_3000, 3, 1'b0, 8,  9};   // inv during fill
        vecs[9]  = '{32'h0000_3000, 0, 1'b0, 8,  9};   // buffer left invalid
        vecs[10] = '{32'h0000_7FE0, 0, 1'b0, 8,  9};   // last line below limit
        vecs[11] = '{32'h0000_8000, 0, 1'b0, 0,  1};   // first address at limit
        vecs[12] = '{32'hFFFF_FFE0, 0, 1'b0, 0,  1};   // top of address space

        rst       = 1'b1;
        immu_read = 1'b0;
        immu_addr = '0;
        inv       = 1'b0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("reset immu_done", 256'(immu_done), 256'(0));
        check("reset read_data", immu_read_data, 256'(0));
        check("reset mem_req", 256'(mem_req), 256'(0));
        check("reset mem_addr", 256'(mem_addr), 256'(0));
        rst = 1'b0;
        @(negedge sys_clk);

        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].addr, vecs[i].inv_mode, vecs[i].wmode, vecs[i].exp_reqs,
                    vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a fill, after beat 3 has been accepted.
        wait_mode = 1'b0;
        immu_read = 1'b1;
        immu_addr = 32'h0000_1000;
        mem_drive();
        acks = 0;
        cyc  = 0;
        while (acks < 4 && cyc < 50) begin
            @(negedge sys_clk);
            cyc++;
            if (mem_ack) acks++;
            mem_drive();
        end
        check("midfill mem_req before reset", 256'(mem_req), 256'(1));
        rst       = 1'b1;
        immu_read = 1'b0;
        #1;
        check("midfill mem_req async drop", 256'(mem_req), 256'(0));
        check("midfill done async", 256'(immu_done), 256'(0));
        check("midfill read_data cleared", immu_read_data, 256'(0));
        check("midfill mem_addr cleared", 256'(mem_addr), 256'(0));
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst     = 1'b0;
        mem_ack = 1'b1;  // stray ack left over from the aborted fill
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("post reset no done", 256'(immu_done), 256'(0));
            check("post reset no mem_req", 256'(mem_req), 256'(0));
        end
        mem_ack = 1'b0;
        run_req(32'h0000_1000, 0, 1'b0, 8, 9, "post_reset_refill");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
